// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: sequences the shared multiplier/divider and HI/LO writeback.
// Optional divide-by-zero trap: define MULDIV_DIVZERO_TRAP_EN to enable.
//
// Ports:
//   clock       in   system clock, rising edge
//   reset       in   synchronous active-low reset
//   start       in   one-cycle request, accepted only in IDLE
//   op          in   0=mult, 1=div, sampled with start
//   b_in[31:0]  in   divisor, sampled with start (zero check only)
//   mult_hi/lo  in   multiplier results
//   div_hi/lo   in   divider results (remainder/quotient)
//   unit_sel    out  latched op, selects unit and HI/LO muxes
//   unit_start  out  one-cycle launch pulse to the selected unit
//   hi_write    out  HI write enable
//   lo_write    out  LO write enable
//   hi_data     out  value for HI (0 outside writeback)
//   lo_data     out  value for LO (0 outside writeback)
//   busy        out  high while not IDLE
//   done        out  one-cycle completion pulse
//   div_zero    out  one-cycle divide-by-zero pulse
module muldiv_sequencer #(
    parameter int MULT_CYCLES = 32,
    parameter int DIV_CYCLES  = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] b_in,
    input  logic [31:0] mult_hi,
    input  logic [31:0] mult_lo,
    input  logic [31:0] div_hi,
    input  logic [31:0] div_lo,
    output logic        unit_sel,
    output logic        unit_start,
    output logic        hi_write,
    output logic        lo_write,
    output logic [31:0] hi_data,
    output logic [31:0] lo_data,
    output logic        busy,
    output logic        done,
    output logic        div_zero
);

`ifdef MULDIV_DIVZERO_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    localparam logic [5:0] MULT_LOAD = 6'(MULT_CYCLES - 1);
    localparam logic [5:0] DIV_LOAD  = 6'(DIV_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN,
        S_WB,
        S_ZERO
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [5:0]  r_cnt;
    logic        r_op;
    logic        w_accept;
    logic        w_zero;

    assign w_accept = (r_state == S_IDLE) && start;
    // With the trap compiled out this is constant 0, so ZERO is unreachable.
    assign w_zero   = TRAP_EN & op & (b_in == 32'd0);

    // State register
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Latency counter and latched operation select
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_cnt <= 6'd0;
            r_op  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op <= op;
            end
            if (r_state == S_LAUNCH) begin
                r_cnt <= r_op ? DIV_LOAD : MULT_LOAD;
            end else if (r_state == S_RUN && r_cnt != 6'd0) begin
                r_cnt <= r_cnt - 6'd1;
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = w_zero ? S_ZERO : S_LAUNCH;
                end
            end
            S_LAUNCH: w_next = S_RUN;
            S_RUN: begin
                if (r_cnt == 6'd0) begin
                    w_next = S_WB;
                end
            end
            S_WB:     w_next = S_IDLE;
            S_ZERO:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        unit_sel   = r_op;
        unit_start = 1'b0;
        hi_write   = 1'b0;
        lo_write   = 1'b0;
        hi_data    = 32'd0;
        lo_data    = 32'd0;
        busy       = (r_state != S_IDLE);
        done       = 1'b0;
        div_zero   = 1'b0;
        unique case (r_state)
            S_IDLE:   ;
            S_LAUNCH: unit_start = 1'b1;
            S_RUN:    ;
            S_WB: begin
                hi_write = 1'b1;
                lo_write = 1'b1;
                done     = 1'b1;
                hi_data  = r_op ? div_hi : mult_hi;
                lo_data  = r_op ? div_lo : mult_lo;
            end
            S_ZERO: begin
                done     = 1'b1;
                div_zero = TRAP_EN;
            end
            default:  ;
        endcase
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Sequences the shared multiplier/divider pair and the HI/LO writeback for the multicycle CPU.
- Accepts a one-cycle start request from ctrl_unit and latches the operation select.
- Launches the selected unit, counts its fixed latency, then writes HI/LO from the correct unit and reports completion.
- Replaces ctrl_unit's ad-hoc cycle counting for mult/div; ctrl_unit stalls on busy and resumes on done.

Parameters:
- MULT_CYCLES, 32, multiplier latency in cycles from unit_start pulse to valid mult_hi/mult_lo (range 1..63)
- DIV_CYCLES, 32, divider latency in cycles from unit_start pulse to valid div_hi/div_lo (range 1..63)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clock
- start  in  1  one-cycle request from control unit; accepted only in IDLE
- op  in  1  0=mult, 1=div; sampled with start
- b_in  in  32  divisor operand (B register), sampled with start; used only for zero check
- mult_hi  in  32  multiplier HI result
- mult_lo  in  32  multiplier LO result
- div_hi  in  32  divider HI result (remainder)
- div_lo  in  32  divider LO result (quotient)
- unit_sel  out  1  Mult_Div select to the units and HI/LO muxes; holds latched op while busy
- unit_start  out  1  one-cycle launch pulse to the selected unit
- hi_write  out  1  HI register write enable
- lo_write  out  1  LO register write enable
- hi_data  out  32  value to HI (selected unit's hi result)
- lo_data  out  32  value to LO (selected unit's lo result)
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle completion pulse
- div_zero  out  1  one-cycle divide-by-zero exception pulse

Behaviour:
- States: IDLE, LAUNCH, RUN, WB, ZERO. 6-bit down-counter cnt. Latched op_q drives unit_sel.
- Reset (reset==0 at a rising edge): state=IDLE, cnt=0, op_q=0. All outputs 0, including hi_data and lo_data.
- Reset mid-operation aborts immediately: no HI/LO write, no done.
- IDLE:
  - start=1 latches op_q=op.
  - Goes to ZERO if op=1 and b_in==0 (feature enabled).
  - Otherwise goes to LAUNCH.
  - start=0 stays in IDLE.
- LAUNCH (1 cycle): unit_start=1; cnt loaded with MULT_CYCLES-1 or DIV_CYCLES-1 per op_q; next state RUN.
- RUN: cnt decrements each cycle; on the cycle cnt==0, next state is WB.
- WB (1 cycle):
  - hi_write=lo_write=done=1.
  - hi_data/lo_data are combinationally muxed from mult_* (op_q=0) or div_* (op_q=1).
  - Next state IDLE.
- ZERO (1 cycle): div_zero=1, done=1, hi_write=lo_write=0; next state IDLE.
- Latency: start accepted at edge E0 gives unit_start in cycle 1, WB in cycle N+2 (N = unit latency), so busy is high for N+2 cycles. ZERO path: done in cycle 1.
- start while busy (including the WB/ZERO cycle) is ignored, with no queuing. start is accepted again in the cycle after done.
- op and b_in are ignored except in the start-accept cycle.
- hi_data/lo_data are 0 outside WB; unit_start and hi/lo_write are never asserted outside LAUNCH/WB.
- unit_sel is stable from LAUNCH through WB and holds its last value in IDLE.

Optional Feature:
- Macro: MULDIV_DIVZERO_TRAP_EN.
- Defined: div with b_in==0 takes the ZERO path, pulsing div_zero and done, and leaves HI/LO unwritten.
- Undefined: the zero check is removed, div_zero is tied to 0, and the ZERO state is unreachable. Divide by zero runs the normal DIV_CYCLES path and writes whatever the divider produces.

Test Plan:
- Mult: reset low 2 cycles then high; start=1, op=0 for 1 cycle; bench unit drives mult_hi=0, mult_lo=15 (3*5) -> unit_start in cycle 1, hi_write=lo_write=done=1 in cycle 34, lo_data=15, hi_data=0, busy high cycles 1..34.
- Div: start, op=1, b_in=4; bench drives div_lo=2, div_hi=1 (9/4) -> unit_sel=1 cycles 1..34; WB in cycle 34 with hi_data=1, lo_data=2.
- Div by zero (macro on): start, op=1, b_in=0 -> cycle 1 div_zero=1, done=1, no unit_start, no hi/lo write. Macro off: normal WB at cycle 34, div_zero stays 0.
- start pulses in cycles 5 and 34 of an active mult -> ignored, exactly one done. start in cycle 35 -> accepted, new unit_start in cycle 36.
- reset=0 in cycle 20 of a div -> cycle 21 busy=0, no hi_write/lo_write/done. A subsequent start works normally.
- Parameter override MULT_CYCLES=1: mult start -> unit_start cycle 1, WB cycle 3.
